// File: rtl/idli_pkg.sv
// Shared types for the idli UART receive path.
//   sqi_data_t      : 4-bit nibble handed to the core
//   uart_rx_state_t : receive FSM state encoding
//   byte_nibble()   : selects the low or high nibble of a received byte
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  // DATA_0..DATA_7 must stay consecutive: the FSM advances through them by increment.
  typedef enum logic [3:0] {
    IDLE,
    DATA_0,
    DATA_1,
    DATA_2,
    DATA_3,
    DATA_4,
    DATA_5,
    DATA_6,
    DATA_7,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  function automatic sqi_data_t byte_nibble(input logic [7:0] b, input logic hi);
    return hi ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/idli_uart_rx_if.sv
// Nibble stream from the UART receiver to the core.
//   data : current nibble
//   vld  : data holds a valid nibble
//   acp  : consumer accepts the nibble this cycle
// master = receiver side, slave = core side.
interface idli_uart_rx_if;
  import idli_pkg::*;

  sqi_data_t data;
  logic      vld;
  logic      acp;

  modport master (output data, output vld, input acp);
  modport slave  (input data, input vld, output acp);

endinterface

// File: rtl/idli_uart_rx_fifo_m.sv
// Byte FIFO between the receive FSM and the nibble output.
//   clk, rst  : clock, asynchronous active-high reset (pointers only)
//   push      : write push_data when not full (or when a pop frees the slot)
//   push_data : byte to store
//   full      : no free slot
//   pop       : drop the head entry
//   pop_data  : head entry (undefined while empty)
//   empty     : no stored entry
module idli_uart_rx_fifo_m #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO is still taken if the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage is data only; it is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/idli_uart_rx_m.sv
// UART receiver: one bit per clock, 8N1 framing, bytes buffered in a small FIFO
// and handed to the core as two nibbles (low first).
//   i_uart_gck     : clock
//   i_uart_rst     : asynchronous active-high reset
//   i_uart_rx      : asynchronous serial line, idle high
//   o_uart_rx      : nibble to the core (0 while nothing is valid)
//   o_uart_rx_vld  : o_uart_rx is valid
//   i_uart_rx_acp  : core accepts the nibble
//   o_uart_rx_ferr : one-cycle pulse after a bad stop bit
//   o_uart_rx_ovf  : one-cycle pulse after a byte was dropped on a full FIFO
module idli_uart_rx_m
  import idli_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic      i_uart_gck,
  input  logic      i_uart_rst,
  input  logic      i_uart_rx,
  output sqi_data_t o_uart_rx,
  output logic      o_uart_rx_vld,
  input  logic      i_uart_rx_acp,
  output logic      o_uart_rx_ferr,
  output logic      o_uart_rx_ovf
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  uart_rx_state_t         state_q;
  uart_rx_state_t         state_d;
  logic                   shift_en;
  logic                   push;
  logic                   ferr_d;
  logic [7:0]             byte_q;
  logic                   ferr_q;
  logic                   ovf_q;
  logic                   nib_sel_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [7:0]             fifo_data;
  logic                   xfer;
  logic                   pop;

  // ---- synchroniser: line idles high, so the flops reset to 1 ----
  always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
    if (i_uart_rst) sync_q <= '1;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], i_uart_rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // ---- receive FSM ----
  always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
    if (i_uart_rst) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    push     = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = DATA_0;
      end
      DATA_0, DATA_1, DATA_2, DATA_3, DATA_4, DATA_5, DATA_6: begin
        shift_en = 1'b1;
        state_d  = uart_rx_state_t'(state_q + 4'd1);
      end
      DATA_7: begin
        shift_en = 1'b1;
        state_d  = STOP;
      end
      STOP: begin
        if (rx_s) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- byte assembly: LSB arrives first, so shift in from the top ----
  always_ff @(posedge i_uart_gck) begin
    if (shift_en) byte_q <= {rx_s, byte_q[7:1]};
  end

  // ---- byte FIFO ----
  idli_uart_rx_fifo_m #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_uart_gck),
    .rst       (i_uart_rst),
    .push      (push),
    .push_data (byte_q),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty)
  );

  // ---- nibble output: valid purely from FIFO state, never from acp ----
  assign o_uart_rx_vld = !fifo_empty;
  assign o_uart_rx     = o_uart_rx_vld ? byte_nibble(fifo_data, nib_sel_q) : '0;
  assign xfer          = o_uart_rx_vld && i_uart_rx_acp;
  assign pop           = xfer && nib_sel_q;

  always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
    if (i_uart_rst) nib_sel_q <= 1'b0;
    else if (xfer)  nib_sel_q <= ~nib_sel_q;
  end

  // ---- status pulses, registered one cycle after the event ----
  always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
    if (i_uart_rst) begin
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      ovf_q  <= push && fifo_full && !pop;
    end
  end

  assign o_uart_rx_ferr = ferr_q;
  assign o_uart_rx_ovf  = ovf_q;

endmodule
